// File: rtl/uart_tx_arbiter.sv
// Packet-atomic round-robin arbiter sharing one uart_tx among NREQ byte-stream requesters.
// A grant is held from a requester's first byte until its last byte, or until a stall timeout.
module uart_tx_arbiter #(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic [7:0]        uart_tx_data,
    output logic              uart_tx_write,
    input  logic              uart_tx_ready,
    output logic [NREQ-1:0]   grant,
    output logic              busy,
    output logic              timeout_err
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {StIdle, StXfer, StStrobe, StGap} state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   gidx_q, gidx_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic            busy_q, busy_d;
    logic [7:0]      data_q, data_d;
    logic            write_q, write_d;
    logic            terr_q, terr_d;
    logic            last_q, last_d;
    logic [CW-1:0]   stall_q, stall_d;

    logic            arb_found;
    logic [PW-1:0]   arb_idx;
    logic            cur_valid;
    logic            cur_last;
    logic [7:0]      cur_data;
    logic            accept;
    logic            stall_expire;

    function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] p, input int unsigned off);
        int unsigned s;
        s = (32'(p) + off) % NREQ;
        return s[PW-1:0];
    endfunction

    // Search starts one past the last owner so every requester gets a turn.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            if (!arb_found && req_valid[wrap_idx(ptr_q, i)]) begin
                arb_found = 1'b1;
                arb_idx   = wrap_idx(ptr_q, i);
            end
        end
    end

    always_comb begin
        cur_data = 8'h00;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gidx_q == PW'(i)) begin
                cur_data = req_data[8*i +: 8];
            end
        end
    end

    assign cur_valid    = req_valid[gidx_q];
    assign cur_last     = req_last[gidx_q];
    assign accept       = (state_q == StXfer) && cur_valid && uart_tx_ready;
    // UART backpressure never counts toward the stall timeout; only a silent owner does.
    assign stall_expire = (TIMEOUT != 0) && (state_q == StXfer) && !cur_valid &&
                          (stall_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            ptr_q   <= PW'(NREQ - 1);
            gidx_q  <= '0;
            grant_q <= '0;
            busy_q  <= 1'b0;
            data_q  <= 8'h00;
            write_q <= 1'b0;
            terr_q  <= 1'b0;
            last_q  <= 1'b0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
            data_q  <= data_d;
            write_q <= write_d;
            terr_q  <= terr_d;
            last_q  <= last_d;
            stall_q <= stall_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (arb_found) begin
                    state_d = StXfer;
                end
            end
            StXfer: begin
                if (accept) begin
                    state_d = StStrobe;
                end else if (stall_expire) begin
                    state_d = StIdle;
                end
            end
            StStrobe: state_d = StGap;
            StGap:    state_d = last_q ? StIdle : StXfer;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        ptr_d   = ptr_q;
        gidx_d  = gidx_q;
        grant_d = grant_q;
        busy_d  = busy_q;
        data_d  = data_q;
        write_d = 1'b0;
        terr_d  = 1'b0;
        last_d  = last_q;
        stall_d = stall_q;
        unique case (state_q)
            StIdle: begin
                if (arb_found) begin
                    gidx_d  = arb_idx;
                    grant_d = NREQ'(1) << arb_idx;
                    busy_d  = 1'b1;
                    stall_d = '0;
                end
            end
            StXfer: begin
                if (accept) begin
                    data_d  = cur_data;
                    write_d = 1'b1;
                    last_d  = cur_last;
                    stall_d = '0;
                end else if (stall_expire) begin
                    grant_d = '0;
                    busy_d  = 1'b0;
                    terr_d  = 1'b1;
                    ptr_d   = gidx_q;
                    stall_d = '0;
                end else if (!cur_valid) begin
                    stall_d = stall_q + CW'(1);
                end
            end
            StGap: begin
                // uart_tx lowers ready a cycle after the strobe, so ready is not looked at here.
                if (last_q) begin
                    ptr_d   = gidx_q;
                    grant_d = '0;
                    busy_d  = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[gidx_q] = 1'b1;
        end
    end

    assign uart_tx_data  = data_q;
    assign uart_tx_write = write_q;
    assign grant         = grant_q;
    assign busy          = busy_q;
    assign timeout_err   = terr_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: expected bytes are queued as stimulus is driven and
// compared against each uart_tx_write strobe.
module tb_uart_tx_arbiter;

    localparam int unsigned NREQ    = 2;
    localparam int unsigned TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [8*NREQ-1:0] req_data = '0;
    logic [NREQ-1:0]   req_last = '0;
    logic [NREQ-1:0]   req_ready;
    logic [7:0]        uart_tx_data;
    logic              uart_tx_write;
    logic              uart_tx_ready = 1'b1;
    logic [NREQ-1:0]   grant;
    logic              busy;
    logic              timeout_err;

    uart_tx_arbiter #(
        .NREQ    (NREQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_write (uart_tx_write),
        .uart_tx_ready (uart_tx_ready),
        .grant         (grant),
        .busy          (busy),
        .timeout_err   (timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wr_cnt = 0;
    int terr_cnt = 0;
    int last_wr_cyc = 0;

    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [8:0] exp_q[$];   // {src, data}

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (timeout_err === 1'b1) terr_cnt++;
        if (uart_tx_write === 1'b1) begin
            wr_cnt++;
            last_wr_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("unexpected_write", {24'h0, uart_tx_data}, 32'hFFFF_FFFF);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                check("wr_data", {24'h0, uart_tx_data}, {24'h0, e[7:0]});
                check("wr_grant", {30'h0, grant}, 32'(1) << e[8]);
            end
        end
    end

    task automatic drive();
        req_valid[0]  = (q0.size() > 0);
        req_valid[1]  = (q1.size() > 0);
        req_data[7:0]  = (q0.size() > 0) ? q0[0][7:0] : 8'h00;
        req_data[15:8] = (q1.size() > 0) ? q1[0][7:0] : 8'h00;
        req_last[0]   = (q0.size() > 0) ? q0[0][8] : 1'b0;
        req_last[1]   = (q1.size() > 0) ? q1[0][8] : 1'b0;
    endtask

    // Ends 2 time units after a rising edge with new inputs driven and settled.
    task automatic step();
        logic [NREQ-1:0] acc;
        acc = req_ready;
        @(posedge clk);
        #1;
        if (acc[0] && q0.size() > 0) void'(q0.pop_front());
        if (acc[1] && q1.size() > 0) void'(q1.pop_front());
        drive();
        #1;
    endtask

    task automatic send(input int r, input logic [7:0] d, input logic last, input logic expect_it);
        if (r == 0) q0.push_back({last, d});
        else        q1.push_back({last, d});
        if (expect_it) exp_q.push_back({r[0], d});
        drive();
        #1;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy || q0.size() != 0 || q1.size() != 0) && n < 300) begin
            step();
            n++;
        end
        check(tag, 32'(n < 300), 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        q0.delete();
        q1.delete();
        drive();
        repeat (3) step();
        reset = 1'b0;
    endtask

    initial begin
        int n;
        int wc0;

        do_reset();
        check("rst_data", {24'h0, uart_tx_data}, 32'h0);
        check("rst_write", {31'h0, uart_tx_write}, 32'h0);
        check("rst_grant", {30'h0, grant}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_terr", {31'h0, timeout_err}, 32'h0);
        check("rst_ready", {30'h0, req_ready}, 32'h0);

        // Single byte: arbitration cycle, accept, strobe, gap, idle.
        send(0, 8'hA5, 1'b1, 1'b1);
        check("t1_idle_grant", {30'h0, grant}, 32'h0);
        check("t1_idle_ready", {30'h0, req_ready}, 32'h0);
        step();
        check("t1_grant", {30'h0, grant}, 32'h1);
        check("t1_busy", {31'h0, busy}, 32'h1);
        check("t1_ready", {30'h0, req_ready}, 32'h1);
        step();
        check("t1_write", {31'h0, uart_tx_write}, 32'h1);
        check("t1_data", {24'h0, uart_tx_data}, 32'hA5);
        check("t1_strobe_ready", {30'h0, req_ready}, 32'h0);
        step();
        check("t1_gap_busy", {31'h0, busy}, 32'h1);
        check("t1_gap_write", {31'h0, uart_tx_write}, 32'h0);
        step();
        check("t1_done_busy", {31'h0, busy}, 32'h0);
        check("t1_done_grant", {30'h0, grant}, 32'h0);

        // Simultaneous requests from reset: req0 first, then req1.
        do_reset();
        send(0, 8'h11, 1'b1, 1'b1);
        send(1, 8'h22, 1'b1, 1'b1);
        drain("t2_drain");
        // Owner pointer is now 1, so req0 wins again over a simultaneous req1.
        send(0, 8'h33, 1'b1, 1'b1);
        send(1, 8'h34, 1'b1, 1'b1);
        drain("t2b_drain");

        // Multi-byte packet is not interleaved with a later request.
        send(0, 8'h01, 1'b0, 1'b1);
        send(0, 8'h02, 1'b0, 1'b1);
        send(0, 8'h03, 1'b1, 1'b1);
        n = 0;
        while (q0.size() > 2 && n < 50) begin step(); n++; end
        check("t3_first_accept", 32'(n < 50), 32'd1);
        send(1, 8'h44, 1'b1, 1'b1);
        drain("t3_drain");

        // Long UART backpressure never times out.
        wc0 = wr_cnt;
        uart_tx_ready = 1'b0;
        send(0, 8'h77, 1'b1, 1'b1);
        repeat (2000) step();
        check("t4_no_write", 32'(wr_cnt - wc0), 32'd0);
        check("t4_no_terr", 32'(terr_cnt), 32'd0);
        check("t4_grant", {30'h0, grant}, 32'h1);
        check("t4_ready_low", {30'h0, req_ready}, 32'h0);
        uart_tx_ready = 1'b1;
        drive();
        #1;
        drain("t4_drain");

        // Stall timeout: owner goes silent mid-packet, waiting req1 takes over.
        send(0, 8'h55, 1'b0, 1'b1);
        n = 0;
        while (grant != 2'b01 && n < 20) begin step(); n++; end
        check("t5_grant0", {30'h0, grant}, 32'h1);
        send(1, 8'h66, 1'b1, 1'b1);
        n = 0;
        while (timeout_err !== 1'b1 && n < 100) begin step(); n++; end
        check("t5_terr_seen", {31'h0, timeout_err}, 32'h1);
        // Strobe, gap, then TIMEOUT silent cycles in transfer before the pulse.
        check("t5_terr_delay", 32'(cyc - last_wr_cyc), 32'(TIMEOUT + 2));
        check("t5_rel_grant", {30'h0, grant}, 32'h0);
        check("t5_rel_busy", {31'h0, busy}, 32'h0);
        step();
        check("t5_terr_pulse", {31'h0, timeout_err}, 32'h0);
        check("t5_grant1", {30'h0, grant}, 32'h2);
        drain("t5_drain");

        // Reset during strobe: pointer returns to NREQ-1, so req0 wins afterwards.
        send(0, 8'hE1, 1'b1, 1'b1);
        drain("t6_pre_drain");
        send(0, 8'hAA, 1'b0, 1'b1);
        send(0, 8'hBB, 1'b1, 1'b0);
        n = 0;
        while (uart_tx_write !== 1'b1 && n < 20) begin step(); n++; end
        check("t6_strobe", {31'h0, uart_tx_write}, 32'h1);
        reset = 1'b1;
        q0.delete();
        drive();
        step();
        check("t6_write", {31'h0, uart_tx_write}, 32'h0);
        check("t6_grant", {30'h0, grant}, 32'h0);
        check("t6_busy", {31'h0, busy}, 32'h0);
        reset = 1'b0;
        send(0, 8'hD0, 1'b1, 1'b1);
        send(1, 8'hCC, 1'b1, 1'b1);
        drain("t6_drain");

        check("exp_empty", 32'(exp_q.size()), 32'd0);
        check("terr_total", 32'(terr_cnt), 32'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
